// File: rtl/led_matrix_scan_ctrl_if.sv
// Frame handoff between the symbol-to-bitmap decoder (master) and the LED scan controller (slave).
// Row r of frame_in is bits [8r+7:8r]; bit 8r+c drives column c.
interface led_matrix_scan_ctrl_if;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output frame_in,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_in,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Row-multiplexed 8x8 LED matrix scanner with a double-buffered frame.
// Each row is lit for DWELL_CYCLES clocks and then blanked for BLANK_CYCLES clocks.
module led_matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    led_matrix_scan_ctrl_if.slave      frame_if,
    input  logic                       enable,
    output logic [7:0]                 row_en,
    output logic [7:0]                 col,
    output logic                       frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_r, state_s;
    logic [2:0]         row_r, row_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [63:0]        active_r, active_s;
    logic [63:0]        pending_r, pending_s;
    logic               pending_full_r, pending_full_s;
    logic               have_frame_r, have_frame_s;
    logic [7:0]         row_en_r, row_en_s;
    logic [7:0]         col_r, col_s;
    logic               frame_done_r, frame_done_s;
    logic               swap_s;
    logic               accept_s;

    function automatic logic [7:0] row_bits(input logic [63:0] frame, input logic [2:0] r);
        logic [5:0] base;
        base = {r, 3'b000};
        return frame[base +: 8];
    endfunction

    // State, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            row_r          <= 3'd0;
            cnt_r          <= '0;
            active_r       <= 64'd0;
            pending_r      <= 64'd0;
            pending_full_r <= 1'b0;
            have_frame_r   <= 1'b0;
            row_en_r       <= 8'd0;
            col_r          <= 8'd0;
            frame_done_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            row_r          <= row_s;
            cnt_r          <= cnt_s;
            active_r       <= active_s;
            pending_r      <= pending_s;
            pending_full_r <= pending_full_s;
            have_frame_r   <= have_frame_s;
            row_en_r       <= row_en_s;
            col_r          <= col_s;
            frame_done_r   <= frame_done_s;
        end
    end

    // Scan sequencing; swaps happen only at frame boundaries so a frame never tears.
    always_comb begin
        state_s      = state_r;
        row_s        = row_r;
        cnt_s        = cnt_r;
        swap_s       = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && (pending_full_r || have_frame_r)) begin
                    swap_s  = pending_full_r;
                    row_s   = 3'd0;
                    cnt_s   = '0;
                    state_s = SHOW;
                end else begin
                    cnt_s = '0;
                end
            end
            SHOW: begin
                if (cnt_r == DWELL_LAST) begin
                    cnt_s   = '0;
                    state_s = BLANK;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    cnt_s = '0;
                    if (row_r == 3'd7) begin
                        frame_done_s = 1'b1;
                        swap_s       = pending_full_r;
                        row_s        = 3'd0;
                        state_s      = enable ? SHOW : IDLE;
                    end else if (enable) begin
                        row_s   = row_r + 3'd1;
                        state_s = SHOW;
                    end else begin
                        row_s   = 3'd0;
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                row_s   = 3'd0;
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase
    end

    // Buffer handoff and next output values, aligned with the next state.
    always_comb begin
        accept_s       = frame_if.frame_valid && !pending_full_r;
        pending_s      = pending_r;
        pending_full_s = pending_full_r;
        active_s       = active_r;
        have_frame_s   = have_frame_r;
        row_en_s       = 8'd0;
        col_s          = 8'd0;
        if (swap_s) begin
            active_s       = pending_r;
            pending_full_s = 1'b0;
            have_frame_s   = 1'b1;
        end else if (accept_s) begin
            pending_s      = frame_if.frame_in;
            pending_full_s = 1'b1;
        end else begin
            pending_full_s = pending_full_r;
        end
        if (state_s == SHOW) begin
            row_en_s = 8'd1 << row_s;
            col_s    = row_bits(active_s, row_s);
        end else begin
            row_en_s = 8'd0;
            col_s    = 8'd0;
        end
    end

    assign frame_if.frame_ready = ~pending_full_r;
    assign row_en               = row_en_r;
    assign col                  = col_r;
    assign frame_done           = frame_done_r;

endmodule

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
- Row-multiplexed scan controller for the 8x8 LED matrix showing slot-reel symbols.
- Accepts a 64-bit frame bitmap (row r = bits [8r+7:8r]) from the symbol-to-bitmap decoder through a valid/ready handshake.
- Double-buffers the frame and drives one row at a time, with a dwell period per row and a blanking gap between rows to suppress ghosting.
- Sits between the symbol decoder and the board matrix pins.

Parameters:
- DWELL_CYCLES, 50000, clocks each row is lit; legal range ≥1.
- BLANK_CYCLES, 500, clocks all rows dark after each row; legal range ≥1.
- CNT_W, 16, width of the dwell/blank counter; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- frame_in  in  64  bitmap; row r = frame_in[8r+7:8r], bit 8r+c = column c.
- frame_valid  in  1  frame_in is valid this cycle.
- frame_ready  out  1  pending buffer empty; the controller can accept a frame.
- enable  in  1  scanning permitted.
- row_en  out  8  one-hot active-high row drive; all zero when dark.
- col  out  8  active-high column data for the lit row; zero when dark.
- frame_done  out  1  one-cycle pulse at the end of row 7's blank period.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, row=0, counter=0. Active and pending buffers are cleared; have_frame=0 and pending_full=0. row_en=0, col=0, frame_done=0, frame_ready=1 on the first cycle after release.
- All outputs are registered. frame_ready = ~pending_full, taken directly from the register.
- Handshake:
  - A frame is accepted on a cycle where frame_valid && frame_ready. pending gets frame_in and pending_full=1 on the next edge.
  - frame_valid while not ready is ignored. The source must hold the frame; no overwrite occurs.
- Swap point: a frame boundary, or IDLE when pending_full. Actions: active←pending, pending_full←0, have_frame←1. A new frame may be accepted on the cycle after the swap.
- IDLE:
  - row_en=0, col=0.
  - If enable && (pending_full || have_frame): swap if pending_full, set row=0, counter=0, go to SHOW.
- SHOW:
  - row_en=1<<row, col=active[8row+7:8row].
  - Held for exactly DWELL_CYCLES clocks, then counter=0, go to BLANK.
- BLANK:
  - row_en=0, col=0, held for exactly BLANK_CYCLES clocks. At the end of the period:
    - If row<7 and enable: row+1, go to SHOW.
    - If row==7: frame_done=1 for one cycle. Swap if pending_full. row=0. Go to SHOW if enable, else IDLE.
    - If row<7 and !enable: row=0, go to IDLE. No frame_done; the partial frame is abandoned.
- enable low during SHOW has no effect until the end of the following BLANK. Rows are never truncated.
- Timing:
  - Frame period = 8·(DWELL_CYCLES+BLANK_CYCLES) clocks.
  - Latency: frame accepted at edge T in IDLE with enable=1 → pending_full at T+1 → swap and SHOW at T+2 → row_en=8'h01 visible from T+2.
- A frame accepted mid-frame takes effect only at the next row-7 boundary. Displayed frames never tear.
- A second frame arriving before the swap is back-pressured (frame_ready=0).
- row_en is never multi-hot. row_en and col are both zero in IDLE and BLANK.
- Counter wraps to 0 on every state change. row wraps 7→0.
- Async reset mid-SHOW forces all outputs to zero immediately, with no glitch to a different row.

Test Plan:
All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset/idle: rst_n=0 then release with enable=0. Required: row_en=0, col=0, frame_ready=1, frame_done=0 for 100 cycles.
- Single frame: enable=1, frame_in=64'h8040201008040201 with valid for 1 cycle.
  - row_en=8'h01, col=8'h01 two cycles after acceptance, for 4 cycles.
  - Then 2 dark cycles.
  - Then row_en=8'h02, col=8'h02, and so on.
  - frame_done pulses once every 48 cycles.
- Back-pressure/no tearing:
  - Mid-frame (row 3), present 64'hFFFF_0000_FFFF_0000. Required: accepted, frame_ready=0.
  - Then present 64'h1 held valid. Required: not accepted until the cycle after the row-7 swap.
  - Rows 4–7 still show the old frame; the next frame shows 0x00/0xFF rows.
- Enable drop: deassert enable during row 2 SHOW. Required: row 2 completes its 4 cycles plus 2 blank cycles, then IDLE with no frame_done. Re-enable restarts at row 0 with the retained frame.
- Async reset mid-scan: pulse rst_n low for 3 ns between edges during row 5. Required: outputs zero immediately, have_frame=0, IDLE after release with no display until a new frame arrives.
- Continuous streaming: source offers a new frame whenever frame_ready=1 for 10 frames. Required: exactly one swap per frame_done, rows always one-hot, and each frame is displayed in full for exactly 48 cycles.
